// File: rtl/sort_frame_loader.sv
// sort_frame_loader: serial-to-parallel frame loader in front of the bitonic
// sort network. Accepted samples fill slots 0..SIZE-1 in arrival order. A
// frame closes on in_last or when the vector is full. The vector is then held
// with out_valid until out_ready consumes it. Unused slots carry a pad value
// that sorts to the tail for the chosen direction.
// Optional feature macro: SORT_LOADER_COUNT_EN adds the out_count port.
// NETWORK_WIDTH / INDEX_WIDTH come from parameters.svh. Defaults apply only
// if that header has not already defined them.

`ifndef NETWORK_WIDTH
  `define NETWORK_WIDTH 8
`endif
`ifndef INDEX_WIDTH
  `define INDEX_WIDTH 4
`endif

module sort_frame_loader #(
  parameter int SIZE = 4,
  parameter bit UP   = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [`NETWORK_WIDTH-1:0]                 in_data,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SIZE-1:0][`NETWORK_WIDTH-1:0]       data_out,
  output logic [SIZE-1:0][`INDEX_WIDTH-1:0]         index_out
`ifdef SORT_LOADER_COUNT_EN
  ,
  output logic [$clog2(SIZE):0]                     out_count
`endif
);

  localparam int W  = `NETWORK_WIDTH;
  localparam int IW = `INDEX_WIDTH;
  localparam int PW = $clog2(SIZE) + 1;

  // Pad value sorts to the tail: max for ascending, zero for descending.
  localparam logic [W-1:0] PAD = UP ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic          ready_reg, ready_next;
  logic          accept;
  logic          consume;
  logic [W-1:0]  data_reg [SIZE];

  // Control registers. in_ready is registered, so it stays low for the first
  // cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= FILL;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
      ready_reg  <= ready_next;
    end
  end

  // Next-state logic: fill until last/full, then present until consumed.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    consume     = 1'b0;
    case (state_reg)
      FILL: begin
        accept = in_valid && ready_reg;
        if (accept) begin
          wr_ptr_next = wr_ptr_reg + PW'(1);
          if (in_last || (wr_ptr_reg == PW'(SIZE - 1))) begin
            cnt_next   = wr_ptr_reg + PW'(1);
            state_next = PRESENT;
          end
        end
      end
      PRESENT: begin
        consume = out_ready;
        if (consume) begin
          state_next  = FILL;
          wr_ptr_next = '0;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
    // Ready follows the state we are entering, so it is high on the recovery
    // cycle right after a frame is consumed.
    ready_next = (state_next == FILL);
  end

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_slot
      // Slot register: load when written, return to pad when consumed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi] <= PAD;
        end else if (consume) begin
          data_reg[gi] <= PAD;
        end else if (accept && (wr_ptr_reg == PW'(gi))) begin
          data_reg[gi] <= in_data;
        end
      end

      assign data_out[gi]  = data_reg[gi];
      // The arrival index is fixed by slot position. Pad slots therefore
      // keep unique indices.
      assign index_out[gi] = IW'(gi);
    end
  endgenerate

  assign in_ready  = ready_reg;
  assign out_valid = (state_reg == PRESENT);

`ifdef SORT_LOADER_COUNT_EN
  assign out_count = out_valid ? cnt_reg : '0;
`endif

endmodule

// File: tb/tb_sort_frame_loader.sv
// Testbench for sort_frame_loader.
// Two instances run in parallel: UP=1 (pad 0xFF) and UP=0 (pad 0x00), both
// driven by the same stimulus. A cycle-level reference model follows the
// frame rules and is checked every cycle. Table vectors and hand-written
// sequences add targeted checks.
module tb_sort_frame_loader;

  localparam int SIZE = 4;
  localparam int W    = 8;
  localparam int IW   = 4;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic in_ready1, out_valid1, in_ready0, out_valid0;
  logic [SIZE-1:0][W-1:0]  data1, data0;
  logic [SIZE-1:0][IW-1:0] idx1, idx0;
`ifdef SORT_LOADER_COUNT_EN
  logic [2:0] cnt_o1, cnt_o0;
`endif

  always #5 clk = ~clk;

  sort_frame_loader #(.SIZE(SIZE), .UP(1'b1)) dut_up (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .data_out(data1), .index_out(idx1)
`ifdef SORT_LOADER_COUNT_EN
    , .out_count(cnt_o1)
`endif
  );

  sort_frame_loader #(.SIZE(SIZE), .UP(1'b0)) dut_dn (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .data_out(data0), .index_out(idx0)
`ifdef SORT_LOADER_COUNT_EN
    , .out_count(cnt_o0)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one frame buffer plus flags.
  logic m_ready = 1'b0;
  logic m_valid = 1'b0;
  int   m_n   = 0;
  int   m_cnt = 0;
  logic [SIZE-1:0][W-1:0] m_frame = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_n     <= 0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
        m_n     <= 0;
      end
    end else begin
      m_ready <= 1'b1;
      if (in_valid && m_ready) begin
        m_frame[SW'(m_n)] <= in_data;
        m_n <= m_n + 1;
        if (in_last || (m_n + 1 == SIZE)) begin
          m_valid <= 1'b1;
          m_ready <= 1'b0;
          m_cnt   <= m_n + 1;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Continuous checker: samples outputs on the falling edge.
  bit   chk_en = 1'b0;
  logic prev_ov = 1'b0;
  int   rise_q[$];
  logic [SIZE-1:0][W-1:0]  e1, e0;
  logic [SIZE-1:0][IW-1:0] idx_exp;

  initial begin
    for (int i = 0; i < SIZE; i++) idx_exp[SW'(i)] = IW'(i);
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("m_valid_up1", 64'(out_valid1), 64'(m_valid));
        check("m_ready_up1", 64'(in_ready1), 64'(m_ready));
        check("m_valid_up0", 64'(out_valid0), 64'(m_valid));
        check("m_ready_up0", 64'(in_ready0), 64'(m_ready));
        check("m_index_up1", 64'(idx1), 64'(idx_exp));
        check("m_index_up0", 64'(idx0), 64'(idx_exp));
        if (m_valid) begin
          for (int i = 0; i < SIZE; i++) begin
            e1[SW'(i)] = (i < m_cnt) ? m_frame[SW'(i)] : 8'hFF;
            e0[SW'(i)] = (i < m_cnt) ? m_frame[SW'(i)] : 8'h00;
          end
          check("m_frame_up1", 64'(data1), 64'(e1));
          check("m_frame_up0", 64'(data0), 64'(e0));
`ifdef SORT_LOADER_COUNT_EN
          check("m_count", 64'(cnt_o1), 64'(m_cnt));
        end else begin
          check("m_count_idle", 64'(cnt_o1), 64'(0));
`endif
        end
        if (out_valid1 && !prev_ov) rise_q.push_back(cyc);
      end
      prev_ov = out_valid1;
    end
  end

  // Inputs change 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [W-1:0] d, input logic l);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 40 && !got; t++) begin
      got = in_ready1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accept", 64'(got), 64'(1));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    int                     len;
    bit                     last;
    logic [SIZE-1:0][W-1:0] s;
    logic [SIZE-1:0][W-1:0] e1;
    logic [SIZE-1:0][W-1:0] e0;
    int                     cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n0;
    vecs[0] = '{4, 1'b1, 32'h01090305, 32'h01090305, 32'h01090305, 4};
    vecs[1] = '{2, 1'b1, 32'h00000207, 32'hFFFF0207, 32'h00000207, 2};
    vecs[2] = '{1, 1'b1, 32'h00000040, 32'hFFFFFF40, 32'h00000040, 1};
    vecs[3] = '{4, 1'b0, 32'hDDCCBBAA, 32'hDDCCBBAA, 32'hDDCCBBAA, 4};
    vecs[4] = '{3, 1'b1, 32'h00332211, 32'hFF332211, 32'h00332211, 3};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(in_ready1), 64'(0));
    check("rst_valid", 64'(out_valid1), 64'(0));
    check("rst_pad_up1", 64'(data1), 64'(32'hFFFFFFFF));
    check("rst_pad_up0", 64'(data0), 64'(32'h00000000));
`ifdef SORT_LOADER_COUNT_EN
    check("rst_count", 64'(cnt_o1), 64'(0));
`endif
    #1;
    rst = 1'b0;
    check("release_ready_low", 64'(in_ready1), 64'(0));
    chk_en = 1'b1;
    tick();
    check("release_ready_high", 64'(in_ready1), 64'(1));

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].len; i++)
        send_sample(vecs[v].s[SW'(i)], vecs[v].last && (i == vecs[v].len - 1));
      check("tbl_latency", 64'(out_valid1), 64'(1));
      check("tbl_ready_low", 64'(in_ready1), 64'(0));
      check("tbl_data_up1", 64'(data1), 64'(vecs[v].e1));
      check("tbl_data_up0", 64'(data0), 64'(vecs[v].e0));
`ifdef SORT_LOADER_COUNT_EN
      check("tbl_count", 64'(cnt_o1), 64'(vecs[v].cnt));
`endif
      consume();
      check("tbl_recover_valid", 64'(out_valid1), 64'(0));
      check("tbl_recover_ready", 64'(in_ready1), 64'(1));
    end

    // in_last without in_valid, and out_ready during FILL, are ignored.
    in_last = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("ign_valid", 64'(out_valid1), 64'(0));
    check("ign_ready", 64'(in_ready1), 64'(1));
    in_last = 1'b0;
    out_ready = 1'b0;
    send_sample(8'h55, 1'b1);
    check("ign_frame", 64'(data1), 64'(32'hFFFFFF55));
    consume();

    // Back-pressure: a fifth sample waits while the full frame is held.
    for (int k = 0; k < 4; k++) send_sample(8'(16 + k), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h14;
    for (int c = 0; c < 10; c++) begin
      check("bp_ready", 64'(in_ready1), 64'(0));
      check("bp_valid", 64'(out_valid1), 64'(1));
      check("bp_hold", 64'(data1), 64'(32'h13121110));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_recover_valid", 64'(out_valid1), 64'(0));
    check("bp_recover_ready", 64'(in_ready1), 64'(1));
    tick();
    check("bp_slot0", 64'(data1[0]), 64'(8'h14));
    check("bp_slot1_pad", 64'(data1[1]), 64'(8'hFF));
    send_sample(8'h15, 1'b1);
    check("bp_frame", 64'(data1), 64'(32'hFFFF1514));
    consume();

    // Reset mid-frame discards the partial frame.
    send_sample(8'h21, 1'b0);
    send_sample(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(out_valid1), 64'(0));
    check("midrst_ready", 64'(in_ready1), 64'(0));
    check("midrst_pad", 64'(data1), 64'(32'hFFFFFFFF));
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) send_sample(8'(49 + k), 1'b0);
    check("midrst_frame_valid", 64'(out_valid1), 64'(1));
    check("midrst_frame", 64'(data1), 64'(32'h34333231));
    consume();

    // Reset while presenting drops the frame.
    send_sample(8'h41, 1'b1);
    check("prst_before", 64'(out_valid1), 64'(1));
    rst = 1'b1;
    tick();
    check("prst_valid", 64'(out_valid1), 64'(0));
    rst = 1'b0;
    tick();
    check("prst_after_valid", 64'(out_valid1), 64'(0));
    check("prst_after_ready", 64'(in_ready1), 64'(1));

    // out_ready tied high: three back-to-back full frames, period 5.
    n0 = rise_q.size();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) send_sample(8'(96 + k), 1'b0);
    repeat (3) tick();
    out_ready = 1'b0;
    check("b2b_pulses", 64'(rise_q.size() - n0), 64'(3));
    if (rise_q.size() - n0 == 3) begin
      check("b2b_period1", 64'(rise_q[n0 + 1] - rise_q[n0]), 64'(5));
      check("b2b_period2", 64'(rise_q[n0 + 2] - rise_q[n0 + 1]), 64'(5));
    end

    // Randomized traffic. The model checks every cycle.
    n0 = rise_q.size();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("rand_frames_seen", 64'(rise_q.size() > n0 + 20), 64'(1));
    check("rand_drained", 64'(out_valid1), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
